div_iter: RTL and testbench

// - Iterative radix-2 restoring divider for the EX stage (DIV, DIVU); result is written to HI/LO.
// - Occupies WIDTH+1 cycles per operation. Drives stall_o, which the hazard unit uses to

---
 rtl/div_iter_pkg.sv | 19 +
 rtl/div_iter.sv | 125 ++++++++++++
 tb/tb_div_iter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative divider and the hazard unit.
package div_iter_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'd0,
      DIV_BYZERO = 2'd1,
      DIV_ON     = 2'd2,
      DIV_END    = 2'd3
   } div_state_e;

   localparam int unsigned DIV_WIDTH = 32;

   // Levels of ready_o/stall_o as seen by the hazard unit.
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_STOP             = 1'b1;
   localparam logic DIV_NO_STOP          = 1'b0;

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage; WIDTH+1 cycles per
// divide, result {remainder, quotient} held until the next completed divide or reset.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic                 annul_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 stall_o
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   div_state_e       state, state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, quo, divisor;
   logic             sign_a, sign_b;
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] rem_step, quo_step;
   logic             last_step;
   logic             neg_a, neg_b;

   // Two's complement negate when neg is set; serves both operand abs and result fix-up.
   function automatic logic [WIDTH-1:0] abs_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (WIDTH'(0) - v) : v;
   endfunction

   assign neg_a     = signed_i & opdata1_i[WIDTH-1];
   assign neg_b     = signed_i & opdata2_i[WIDTH-1];
   assign last_step = (count == CW'(WIDTH - 1));

   // Restoring step: the top bit of the WIDTH+1 bit trial is the borrow that picks the quotient bit.
   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      trial  = rem_sh - {1'b0, divisor};
      if (trial[WIDTH]) begin
         rem_step = rem_sh[WIDTH-1:0];
         quo_step = {quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_step = trial[WIDTH-1:0];
         quo_step = {quo[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      state_nxt = state;
      ready_o   = DIV_RESULT_NOT_READY;
      stall_o   = DIV_NO_STOP;
      case (state)
         DIV_FREE: begin
            if (start_i) begin
               stall_o   = DIV_STOP;
               state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
            end
         end
         DIV_BYZERO: begin
            stall_o   = DIV_STOP;
            state_nxt = annul_i ? DIV_FREE : DIV_END;
         end
         DIV_ON: begin
            stall_o = DIV_STOP;
            if (annul_i)
               state_nxt = DIV_FREE;
            else if (last_step)
               state_nxt = DIV_END;
         end
         DIV_END: begin
            ready_o   = DIV_RESULT_READY;
            state_nxt = DIV_FREE;
         end
         default: state_nxt = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DIV_FREE;
         count    <= '0;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         result_o <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            DIV_FREE: begin
               if (start_i && (opdata2_i != '0)) begin
                  count   <= '0;
                  rem     <= '0;
                  quo     <= abs_neg(opdata1_i, neg_a);
                  divisor <= abs_neg(opdata2_i, neg_b);
                  sign_a  <= neg_a;
                  sign_b  <= neg_b;
               end
            end
            DIV_BYZERO: begin
               if (!annul_i)
                  result_o <= '0;
            end
            DIV_ON: begin
               if (!annul_i) begin
                  rem   <= rem_step;
                  quo   <= quo_step;
                  count <= count + CW'(1);
                  // Sign fix-up is folded into the last step so result_o is final in END.
                  if (last_step)
                     result_o <= {abs_neg(rem_step, sign_a), abs_neg(quo_step, sign_a ^ sign_b)};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus random divides against
// an arithmetic reference model.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic        annul_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stall_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [63:0] last_exp = '0;

   div_iter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .signed_i  (signed_i),
      .annul_i   (annul_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .result_o  (result_o),
      .ready_o   (ready_o),
      .stall_o   (stall_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: HI = remainder, LO = quotient; C-style truncating signed division.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint sa, sb, q, r;
      if (b == 32'd0)
         return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge of the following FREE cycle.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic ann_with_start);
      logic [63:0] exp;
      int unsigned cyc, lat;
      exp = ref_div(a, b, s);
      lat = (b == 32'd0) ? 2 : 33;
      opdata1_i = a;
      opdata2_i = b;
      signed_i  = s;
      start_i   = 1'b1;
      annul_i   = ann_with_start;
      #1;
      check_eq("stall_start", {63'd0, stall_o}, 64'd1);
      @(negedge clk);
      start_i = 1'b0;
      annul_i = 1'b0;
      cyc     = 1;
      while (!ready_o && cyc < 60) begin
         check_eq("stall_busy", {63'd0, stall_o}, 64'd1);
         @(negedge clk);
         cyc++;
      end
      check_eq("latency", 64'(cyc), 64'(lat));
      check_eq("ready", {63'd0, ready_o}, 64'd1);
      check_eq("stall_end", {63'd0, stall_o}, 64'd0);
      check_eq("result", result_o, exp);
      last_exp = exp;
      @(negedge clk);
      check_eq("ready_pulse", {63'd0, ready_o}, 64'd0);
      check_eq("result_hold", result_o, exp);
   endtask

   // Start a divide and annul it in cycle ann_cyc (>= 1).
   task automatic annul_div(input logic [31:0] a, input logic [31:0] b, input int unsigned ann_cyc);
      int unsigned seen;
      opdata1_i = a;
      opdata2_i = b;
      signed_i  = 1'b0;
      start_i   = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (ann_cyc - 1) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      check_eq("annul_stall", {63'd0, stall_o}, 64'd0);
      check_eq("annul_ready", {63'd0, ready_o}, 64'd0);
      check_eq("annul_result", result_o, last_exp);
      seen = 0;
      repeat (40) begin
         if (ready_o) seen++;
         @(negedge clk);
      end
      check_eq("annul_no_ready", 64'(seen), 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      rst       = 1'b1;
      start_i   = 1'b0;
      signed_i  = 1'b0;
      annul_i   = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_eq("rst_result", result_o, 64'd0);
      check_eq("rst_ready", {63'd0, ready_o}, 64'd0);
      check_eq("rst_stall", {63'd0, stall_o}, 64'd0);

      do_div(32'd100, 32'd7, 1'b0, 1'b0);
      check_eq("divu_100_7", result_o, {32'd2, 32'd14});
      do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      check_eq("div_m7_2", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      check_eq("div_ovf", result_o, {32'h0, 32'h8000_0000});
      do_div(32'd5, 32'd0, 1'b0, 1'b0);
      do_div(32'd1000, 32'd33, 1'b1, 1'b1);

      do_div(32'd77, 32'd5, 1'b0, 1'b0);
      annul_div(32'd12345, 32'd17, 10);
      annul_div(32'd9, 32'd0, 1);

      // Reset in the middle of a divide, then back-to-back divides.
      opdata1_i = 32'd5000;
      opdata2_i = 32'd3;
      signed_i  = 1'b0;
      start_i   = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_exp = '0;
      check_eq("midrst_result", result_o, 64'd0);
      check_eq("midrst_ready", {63'd0, ready_o}, 64'd0);
      check_eq("midrst_stall", {63'd0, stall_o}, 64'd0);
      do_div(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b0);
      do_div(32'hDEAD_BEEF, 32'hFFFF_F000, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = 32'($urandom_range(1, 15));
            3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
         s = 1'($urandom_range(0, 1));
         do_div(a, b, s, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
